// File: rtl/coef_loader.sv
// Byte-serial coefficient loader: assembles MSB-first bytes into MEM_WIDTH words,
// writes NUM_COEF words to the coefficient port, then verifies a modulo-256 checksum byte.
module coef_loader #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned MEM_WIDTH  = 24,
    parameter int unsigned NUM_COEF   = 32
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  Start_SI,
    input  logic                  ByteValid_SI,
    input  logic [7:0]            Byte_DI,
    output logic                  ByteReady_SO,
    output logic                  WrEn_SO,
    output logic [ADDR_WIDTH-1:0] Addr_DO,
    output logic [MEM_WIDTH-1:0]  PAR_Out_DO,
    output logic                  Busy_SO,
    output logic                  Done_SO,
    output logic                  Err_SO
);

    localparam int unsigned BPW = MEM_WIDTH / 8;
    localparam int unsigned CW  = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StWrite,
        StCheck,
        StDone,
        StErr
    } state_e;

    state_e                state_q;
    logic [CW-1:0]         byte_cnt_q;
    logic [MEM_WIDTH-1:0]  word_q;
    logic [7:0]            csum_q;
    logic [MEM_WIDTH-1:0]  word_shift;
    logic                  accept;

    // Ready is combinational on Start so a restart cycle never swallows a byte.
    assign ByteReady_SO = ((state_q == StRecv) || (state_q == StCheck)) && !Start_SI;
    assign accept       = ByteValid_SI && ByteReady_SO;
    assign word_shift   = (word_q << 8) | MEM_WIDTH'(Byte_DI);

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            word_q     <= '0;
            csum_q     <= '0;
            WrEn_SO    <= 1'b0;
            Addr_DO    <= '0;
            PAR_Out_DO <= '0;
            Busy_SO    <= 1'b0;
            Done_SO    <= 1'b0;
            Err_SO     <= 1'b0;
        end else if (Start_SI) begin
            state_q    <= StRecv;
            byte_cnt_q <= '0;
            word_q     <= '0;
            csum_q     <= '0;
            WrEn_SO    <= 1'b0;
            Addr_DO    <= '0;
            Busy_SO    <= 1'b1;
            Done_SO    <= 1'b0;
            Err_SO     <= 1'b0;
        end else begin
            unique case (state_q)
                StRecv: begin
                    if (accept) begin
                        csum_q <= csum_q + Byte_DI;
                        if (byte_cnt_q == CW'(BPW - 1)) begin
                            PAR_Out_DO <= word_shift;
                            word_q     <= '0;
                            byte_cnt_q <= '0;
                            WrEn_SO    <= 1'b1;
                            state_q    <= StWrite;
                        end else begin
                            word_q     <= word_shift;
                            byte_cnt_q <= byte_cnt_q + CW'(1);
                        end
                    end
                end
                StWrite: begin
                    WrEn_SO <= 1'b0;
                    if (Addr_DO == ADDR_WIDTH'(NUM_COEF - 1)) begin
                        state_q <= StCheck;
                    end else begin
                        Addr_DO <= Addr_DO + ADDR_WIDTH'(1);
                        state_q <= StRecv;
                    end
                end
                StCheck: begin
                    if (accept) begin
                        Busy_SO <= 1'b0;
                        if (Byte_DI == csum_q) begin
                            Done_SO <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            Err_SO  <= 1'b1;
                            state_q <= StErr;
                        end
                    end
                end
                StIdle, StDone, StErr: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= StIdle;
                    Busy_SO <= 1'b0;
                    WrEn_SO <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coef_loader.sv
// Randomized scoreboard bench for coef_loader: stimulus predicts writes into a queue,
// a negedge monitor pops and compares each WrEn_SO pulse (address, data, latency).
module tb_coef_loader;

    localparam int unsigned AW  = 5;
    localparam int unsigned MW  = 24;
    localparam int unsigned NC  = 32;
    localparam int unsigned BPW = MW / 8;

    logic          Clk_CI = 1'b0;
    logic          Rst_RBI = 1'b0;
    logic          Start_SI = 1'b0;
    logic          ByteValid_SI = 1'b0;
    logic [7:0]    Byte_DI = 8'h00;
    logic          ByteReady_SO;
    logic          WrEn_SO;
    logic [AW-1:0] Addr_DO;
    logic [MW-1:0] PAR_Out_DO;
    logic          Busy_SO;
    logic          Done_SO;
    logic          Err_SO;

    coef_loader #(
        .ADDR_WIDTH (AW),
        .MEM_WIDTH  (MW),
        .NUM_COEF   (NC)
    ) dut (
        .Clk_CI       (Clk_CI),
        .Rst_RBI      (Rst_RBI),
        .Start_SI     (Start_SI),
        .ByteValid_SI (ByteValid_SI),
        .Byte_DI      (Byte_DI),
        .ByteReady_SO (ByteReady_SO),
        .WrEn_SO      (WrEn_SO),
        .Addr_DO      (Addr_DO),
        .PAR_Out_DO   (PAR_Out_DO),
        .Busy_SO      (Busy_SO),
        .Done_SO      (Done_SO),
        .Err_SO       (Err_SO)
    );

    always #5 Clk_CI = ~Clk_CI;

    typedef struct {
        int unsigned addr;
        int unsigned data;
        int unsigned cyc;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    // Reference model state: bytes collected for the current word and load.
    int unsigned m_bytes[$];
    int unsigned m_addr = 0;
    int unsigned m_sum = 0;

    always @(posedge Clk_CI) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write strobe must match the oldest predicted write.
    always @(negedge Clk_CI) begin
        if (Rst_RBI) begin
            chk("done_err_exclusive", {31'd0, Done_SO & Err_SO}, 32'd0);
            if (WrEn_SO) begin
                chk("ready_low_in_write", {31'd0, ByteReady_SO}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(Addr_DO), e.addr);
                    chk("wr_data", 32'(PAR_Out_DO), e.data);
                    chk("wr_latency_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic model_clear();
        m_bytes.delete();
        m_addr = 0;
        m_sum  = 0;
    endtask

    // Called at a negedge; returns #1 after the accepting posedge with valid dropped.
    task automatic send_byte(input logic [7:0] b, input int unsigned max_gap, output bit ok);
        int unsigned gap;
        gap = $urandom_range(max_gap, 0);
        ok  = 1'b0;
        repeat (gap) begin
            ByteValid_SI = 1'b0;
            Byte_DI      = 8'($urandom);
            @(negedge Clk_CI);
        end
        ByteValid_SI = 1'b1;
        Byte_DI      = b;
        for (int i = 0; i < 8; i++) begin
            if (ByteReady_SO) begin
                @(posedge Clk_CI);
                #1;
                ok = 1'b1;
                break;
            end
            @(negedge Clk_CI);
        end
        ByteValid_SI = 1'b0;
        if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic data_byte(input logic [7:0] b, input int unsigned max_gap);
        bit ok;
        send_byte(b, max_gap, ok);
        if (ok) begin
            m_sum = (m_sum + b) % 256;
            m_bytes.push_back(b);
            if (m_bytes.size() == BPW) begin
                int unsigned w;
                w = 0;
                foreach (m_bytes[i]) w = w * 256 + m_bytes[i];
                exp_q.push_back('{addr: m_addr, data: w, cyc: cyc});
                m_addr++;
                m_bytes.delete();
            end
        end
        @(negedge Clk_CI);
    endtask

    task automatic pulse_start();
        Start_SI = 1'b1;
        @(posedge Clk_CI);
        #1;
        Start_SI = 1'b0;
        model_clear();
        chk("start_busy", {31'd0, Busy_SO}, 32'd1);
        chk("start_clears_done_err", {30'd0, Done_SO, Err_SO}, 32'd0);
        @(negedge Clk_CI);
    endtask

    task automatic load(input bit rand_data, input bit bad_sum, input int unsigned max_gap);
        bit          ok;
        logic [7:0]  cs;
        pulse_start();
        for (int k = 0; k < NC; k++) begin
            for (int j = 0; j < BPW; j++) begin
                data_byte(rand_data ? 8'($urandom) : 8'(k), max_gap);
            end
        end
        cs = 8'(m_sum) + (bad_sum ? 8'd1 : 8'd0);
        send_byte(cs, max_gap, ok);
        @(negedge Clk_CI);
        chk("load_all_written", exp_q.size(), 32'd0);
        chk("load_done", {31'd0, Done_SO}, {31'd0, !bad_sum});
        chk("load_err", {31'd0, Err_SO}, {31'd0, bad_sum});
        chk("load_busy_low", {31'd0, Busy_SO}, 32'd0);
    endtask

    task automatic present_ignored(input string name, input logic done_exp);
        repeat (4) begin
            ByteValid_SI = 1'b1;
            Byte_DI      = 8'($urandom);
            #1;
            chk(name, {31'd0, ByteReady_SO}, 32'd0);
            @(negedge Clk_CI);
        end
        ByteValid_SI = 1'b0;
        chk("ignored_done_unchanged", {31'd0, Done_SO}, {31'd0, done_exp});
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {ByteReady_SO, WrEn_SO, Busy_SO, Done_SO, Err_SO}, 32'd0);
        chk({name, "_addr"}, 32'(Addr_DO), 32'd0);
        chk({name, "_data"}, 32'(PAR_Out_DO), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        Rst_RBI = 1'b0;
        #12;
        chk_all_zero("reset_outputs");
        @(negedge Clk_CI);
        Rst_RBI = 1'b1;
        repeat (2) @(negedge Clk_CI);

        present_ignored("idle_ready_low", 1'b0);
        chk("idle_busy_low", {31'd0, Busy_SO}, 32'd0);

        // Full load of k*0x010101 with correct checksum, then DONE ignores bytes.
        load(1'b0, 1'b0, 3);
        present_ignored("done_ready_low", 1'b1);

        load(1'b0, 1'b1, 2);
        load(1'b1, 1'b0, 1);
        load(1'b1, 1'b1, 0);

        // Gapped single word.
        pulse_start();
        data_byte(8'hAB, 4);
        data_byte(8'hCD, 4);
        data_byte(8'hEF, 4);
        repeat (2) @(negedge Clk_CI);
        chk("gap_word_written", exp_q.size(), 32'd0);

        // Restart mid-word: the byte offered alongside Start must be refused.
        pulse_start();
        data_byte(8'h11, 1);
        data_byte(8'h22, 1);
        Start_SI     = 1'b1;
        ByteValid_SI = 1'b1;
        Byte_DI      = 8'h99;
        #1;
        chk("restart_ready_low", {31'd0, ByteReady_SO}, 32'd0);
        @(posedge Clk_CI);
        #1;
        Start_SI     = 1'b0;
        ByteValid_SI = 1'b0;
        model_clear();
        chk("restart_addr_zero", 32'(Addr_DO), 32'd0);
        @(negedge Clk_CI);
        data_byte(8'h33, 2);
        data_byte(8'h44, 2);
        data_byte(8'h55, 2);
        repeat (2) @(negedge Clk_CI);
        chk("restart_word_written", exp_q.size(), 32'd0);

        // Reset during the WRITE of address 5.
        pulse_start();
        for (int n = 0; n < 5 * BPW + 2; n++) data_byte(8'($urandom), 2);
        send_byte(8'h5A, 0, ok);
        chk("pre_reset_wren", {31'd0, WrEn_SO}, 32'd1);
        chk("pre_reset_addr", 32'(Addr_DO), 32'd5);
        Rst_RBI = 1'b0;
        #1;
        chk_all_zero("reset_mid_write");
        model_clear();
        @(negedge Clk_CI);
        chk("reset_pending_writes", exp_q.size(), 32'd0);
        Rst_RBI = 1'b1;
        repeat (2) @(negedge Clk_CI);
        present_ignored("post_reset_idle_ready_low", 1'b0);
        chk("post_reset_busy_low", {31'd0, Busy_SO}, 32'd0);

        pulse_start();
        for (int n = 0; n < BPW; n++) data_byte(8'($urandom), 1);
        repeat (2) @(negedge Clk_CI);
        chk("final_word_written", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
